// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter:
//     - FSM state encoding (IDLE=0, ACCESS=1, RESP=2)
//     - default data / word-index widths
//     - requester identities (CPU=0, LD=1) and the grant -> id helper
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int DADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_t;

  // Grant vector is one-hot: bit 0 = CPU, bit 1 = loader.
  function automatic req_id_t grant_to_id(input logic [1:0] grant);
    return grant[1] ? REQ_LD : REQ_CPU;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
//   Combinational winner selection between the CPU and loader requesters.
//   A lone request always wins; on a tie the requester that was NOT granted
//   last wins. Holding last_grant at REQ_LD therefore yields fixed CPU priority.
//
// Ports
//   cpu_req    in   CPU request
//   ld_req     in   loader/debug request
//   last_grant in   identity of the most recently granted requester
//   grant      out  one-hot grant {ld, cpu}, all-zero when nobody requests
// -----------------------------------------------------------------------------
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       cpu_req,
  input  logic       ld_req,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (cpu_req && ld_req) begin
      grant = (last_grant == REQ_CPU) ? 2'b10 : 2'b01;
    end else if (cpu_req) begin
      grant = 2'b01;
    end else if (ld_req) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter in front of a single-port synchronous data memory.
//   Requesters: the CPU MEM stage and a loader/debug port. Each transfer runs
//   IDLE -> ACCESS -> RESP -> IDLE, one transfer per three clocks. All state
//   updates on the falling edge of clock, so a rising-edge pipeline sees the
//   ack half a cycle after it is raised and can drop its request before the
//   arbiter samples again in IDLE.
//
//   Build option: define DMEM_ARB_RR_EN for round-robin tie breaking;
//   otherwise the CPU always wins ties and no last-grant register exists.
//
// Ports
//   clock, reset            clock (negedge active), synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request, byte address (bit 0 ignored)
//   cpu_ack/rdata           one-cycle completion pulse / load data (0 on writes)
//   cpu_stall               cpu_req & ~cpu_ack, combinational
//   ld_*                    loader port, same meaning as cpu_*
//   mem_en/we/addr/wdata    memory strobe, write strobe, word index, write data
//   mem_rdata               memory read data, valid the cycle after mem_en
//   busy                    high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DADDR_W = DADDR_W_DEF
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [15:0]        cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ack,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_stall,

  input  logic               ld_req,
  input  logic               ld_we,
  input  logic [15:0]        ld_addr,
  input  logic [DATA_W-1:0]  ld_wdata,
  output logic               ld_ack,
  output logic [DATA_W-1:0]  ld_rdata,

  output logic               mem_en,
  output logic               mem_we,
  output logic [DADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,

  output logic               busy
);

  state_t            state;
  req_id_t           win_id;
  logic              win_we;
  req_id_t           last_grant;
  logic [1:0]        grant;

  logic              sel_we;
  logic [15:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Byte-address bit 0 and bits above the word index are deliberately dropped,
  // which gives the modulo-memory-size wrap-around.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{sel_addr[0], sel_addr[15:DADDR_W+1]};

`ifndef DMEM_ARB_RR_EN
  // Fixed priority: pretending the loader was always granted last makes the
  // picker hand every tie to the CPU.
  assign last_grant = REQ_LD;
`endif

  dmem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .ld_req     (ld_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant[1]) begin
      sel_we    = ld_we;
      sel_addr  = ld_addr;
      sel_wdata = ld_wdata;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(negedge clock) begin
    if (reset) begin
      state     <= IDLE;
      win_id    <= REQ_CPU;
      win_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      ld_ack    <= 1'b0;
      ld_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= REQ_LD;
`endif
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;
      unique case (state)
        // IDLE: latch the winner straight into the memory-facing registers
        IDLE: begin
          if (|grant) begin
            win_id    <= grant_to_id(grant);
            win_we    <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr[DADDR_W:1];
            mem_wdata <= sel_wdata;
            busy      <= 1'b1;
            state     <= ACCESS;
`ifdef DMEM_ARB_RR_EN
            last_grant <= grant_to_id(grant);
`endif
          end
        end
        // ACCESS: memory samples the strobe at this edge
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= RESP;
        end
        // RESP: read data is now valid; return it with the ack pulse
        RESP: begin
          if (win_id == REQ_LD) begin
            ld_ack   <= 1'b1;
            ld_rdata <= win_we ? '0 : mem_rdata;
          end else begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= win_we ? '0 : mem_rdata;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, data word width.
REQ-002 Parameter DADDR_W, default 10, word-index width of data memory (1024 words).
REQ-003 The block SHALL have one clock and a synchronous active-high reset, ports named clock and reset; all state SHALL update on the negative edge of clock.
REQ-004 clock  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cpu_req / cpu_we  in  1/1  MEM-stage access request / write enable.
REQ-007 cpu_addr / cpu_wdata  in  16/DATA_W  byte address / store data.
REQ-008 cpu_ack / cpu_rdata  out  1/DATA_W  one-cycle completion pulse / load data.
REQ-009 cpu_stall  out  1  freeze the pipeline: cpu_req high and CPU transfer not yet acked.
REQ-010 ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata: loader/debug port, same widths and meaning as the cpu_* ports.
REQ-011 mem_en / mem_we  out  1/1  memory access strobe / write strobe.
REQ-012 mem_addr / mem_wdata  out  DADDR_W/DATA_W  word index / write data.
REQ-013 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-016 IDLE: with no request, remain in IDLE; with any request, latch the winner's we/addr/wdata and the winner's identity, then go to ACCESS.
REQ-017 ACCESS: mem_en=1, mem_we=latched we, mem_addr=latched addr[DADDR_W:1], mem_wdata=latched wdata; next state RESP.
REQ-018 RESP: assert the winner's ack for exactly one cycle, with rdata=mem_rdata captured from the ACCESS cycle (writes return 0); next state IDLE unconditionally.
REQ-019 Latency: a request first sampled in IDLE at edge N SHALL be acked in the cycle following edge N+2; throughput is one transfer per 3 cycles.
REQ-020 Requesters SHALL hold req and fields stable until ack and SHALL drop req on the edge that samples ack; req and fields SHALL be ignored outside IDLE.
REQ-021 Address bit 0 SHALL be ignored; address bits above DADDR_W SHALL be ignored (wrap-around modulo 1024 words).
REQ-022 Simultaneous requests in IDLE SHALL be resolved by the arbitration policy (REQ-027); the loser stays pending and its stall (if CPU) stays high.
REQ-023 cpu_stall SHALL be combinational: cpu_req & ~cpu_ack.
REQ-024 mem_en SHALL be low in IDLE and RESP; no memory write SHALL occur outside ACCESS.

Reset
REQ-025 On reset: state=IDLE; all ack, rdata, mem_* outputs and busy=0; last-grant pointer=loader (so CPU wins the first tie).
REQ-026 Reset asserted in ACCESS or RESP SHALL abort the transfer with no ack; the requester re-issues.

Configuration
REQ-027 With DMEM_ARB_RR_EN defined, ties SHALL go to the requester not granted last (round-robin); without it, the CPU SHALL always win ties (fixed priority) and the last-grant pointer SHALL be absent.

Structure
REQ-028 Shared package dmem_arb_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1, RESP=2), DATA_W/DADDR_W defaults and requester IDs (CPU=0, LD=1).
REQ-029 Winner selection SHALL be one sub-module, dmem_arb_pick (two requests plus last-grant pointer in, one-hot grant out).

Verification
REQ-030 CPU load alone: DMemory[5]=16'h00AB, cpu_req=1 with addr=10 and we=0 -> mem_en at N+1 with mem_addr=5; cpu_ack and cpu_rdata=00AB at N+2; cpu_stall high for 3 cycles.
REQ-031 Loader write then CPU read: ld write of 16'h1234 to addr 4, then cpu read of addr 4 -> cpu_rdata=1234.
REQ-032 Tie: both requests held continuously for 4 transfers -> RR build grants CPU,LD,CPU,LD; fixed build grants CPU,CPU,CPU,CPU and ld_ack never fires.
REQ-033 Reset in ACCESS of a CPU write to addr 6 (value 16'hFFFF) -> no cpu_ack; state IDLE; all outputs 0 one cycle later.
REQ-034 Wrap: cpu write 16'h0055 to addr 16'h0802 -> mem_addr=1; a later read of addr 2 returns 0055.
